// File: rtl/s2mm_address_generator.sv
// ---------------------------------------------------------------------------
// s2mm_address_generator
//
// Hands out chunk start addresses of a ring buffer to an S2MM command
// converter and retires them as datamover status words come back. The number
// of issued-but-unretired chunks is capped at MAX_OUTSTANDING. Any bad status,
// or a status that arrives when nothing is outstanding, latches a sticky
// error and parks the block in HALT. The only way out of HALT is reset.
//
// Ports
//   address_out_aclk     in   1   single rising-edge clock
//   address_out_aresetn  in   1   synchronous active-low reset
//   enable               in   1   level, 1 = keep issuing addresses
//   address_out_tdata    out  32  chunk start address (AXI-Stream)
//   address_out_tvalid   out  1   AXI-Stream valid
//   address_out_tready   in   1   AXI-Stream ready
//   status_in_tdata      in   32  S2MM status: [31] EOP, [30:8] bytes,
//                                 [7] OKAY, [6:4] SLV/DEC/INT error, [3:0] tag
//   status_in_tvalid     in   1   status valid
//   status_in_tready     out  1   status ready (1 whenever out of reset)
//   outstanding          out  4   issued minus completed chunks
//   chunks_done          out  32  count of OKAY statuses, wraps
//   last_bytes           out  23  bytes field of the most recent OKAY status
//   error                out  1   sticky fault flag
// ---------------------------------------------------------------------------
module s2mm_address_generator #(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned CHUNK_BYTES     = 1024,
    parameter int unsigned NUM_CHUNKS      = 16,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        address_out_aclk,
    input  logic        address_out_aresetn,
    input  logic        enable,
    output logic [31:0] address_out_tdata,
    output logic        address_out_tvalid,
    input  logic        address_out_tready,
    input  logic [31:0] status_in_tdata,
    input  logic        status_in_tvalid,
    output logic        status_in_tready,
    output logic [3:0]  outstanding,
    output logic [31:0] chunks_done,
    output logic [22:0] last_bytes,
    output logic        error
);

    localparam int unsigned    IDX_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHUNKS - 1);
    localparam logic [3:0]     MAX_OUT  = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Start address of ring slot idx; the sum is deliberately 32-bit truncated.
    function automatic logic [31:0] chunk_addr_f(input logic [IDX_W-1:0] idx);
        chunk_addr_f = BASE_ADDR + (32'(idx) * 32'(CHUNK_BYTES));
    endfunction

    // A status is good only when OKAY is set and none of the error bits are.
    function automatic logic status_okay_f(input logic [31:0] st);
        status_okay_f = st[7] & (st[6:4] == 3'b000);
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    logic [IDX_W-1:0]  idx_r;
    logic [IDX_W-1:0]  idx_next_s;
    logic [31:0]       tdata_r;
    logic              tvalid_r;
    logic              tvalid_next_s;
    logic              status_tready_r;
    logic [3:0]        outstanding_r;
    logic [3:0]        outstanding_next_s;
    logic [31:0]       chunks_done_r;
    logic [22:0]       last_bytes_r;
    logic              error_r;

    logic              addr_hs_s;
    logic              stat_hs_s;
    logic              underflow_s;
    logic              bad_status_s;
    logic              fault_s;
    logic              beat_pending_s;
    logic              retire_s;
    logic              count_okay_s;

    // EOP and TAG carry nothing this block acts on.
    logic              unused_status_bits_s;
    assign unused_status_bits_s = &{1'b0, status_in_tdata[31], status_in_tdata[3:0]};

    assign addr_hs_s      = tvalid_r & address_out_tready;
    assign stat_hs_s      = status_in_tvalid & status_tready_r;
    assign underflow_s    = stat_hs_s & (outstanding_r == 4'd0);
    assign bad_status_s   = stat_hs_s & ~status_okay_f(status_in_tdata);
    assign fault_s        = underflow_s | bad_status_s;
    // A beat is still pending when it is presented but not accepted this cycle.
    assign beat_pending_s = tvalid_r & ~address_out_tready;
    assign retire_s       = stat_hs_s & (outstanding_r != 4'd0);
    // Counters freeze in HALT and never count a status that faulted.
    assign count_okay_s   = stat_hs_s & ~fault_s & (state_r != ST_HALT);

    // FSM state register.
    always_ff @(posedge address_out_aclk) begin
        if (!address_out_aresetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fault_s) begin
                    state_next_s = ST_HALT;
                end else if (enable) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (fault_s) begin
                    state_next_s = ST_HALT;
                end else if (!enable && !beat_pending_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_HALT: begin
                state_next_s = ST_HALT;
            end
            default: begin
                state_next_s = ST_HALT;
            end
        endcase
    end

    // FSM output / datapath next-value logic.
    always_comb begin
        idx_next_s         = idx_r;
        outstanding_next_s = outstanding_r;
        tvalid_next_s      = 1'b0;

        if (addr_hs_s) begin
            if (idx_r == IDX_LAST) begin
                idx_next_s = '0;
            end else begin
                idx_next_s = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end
        end else begin
            idx_next_s = idx_r;
        end

        // Simultaneous issue and retire cancel out.
        case ({addr_hs_s, retire_s})
            2'b10:   outstanding_next_s = outstanding_r + 4'd1;
            2'b01:   outstanding_next_s = outstanding_r - 4'd1;
            default: outstanding_next_s = outstanding_r;
        endcase

        // A pending beat always survives; a new one needs to stay in ISSUE and
        // have room after this cycle's issue/retire, which keeps back-to-back
        // beats going without overshooting the limit.
        if (beat_pending_s) begin
            tvalid_next_s = 1'b1;
        end else if ((state_r == ST_ISSUE) && (state_next_s == ST_ISSUE) &&
                     (outstanding_next_s < MAX_OUT)) begin
            tvalid_next_s = 1'b1;
        end else begin
            tvalid_next_s = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge address_out_aclk) begin
        if (!address_out_aresetn) begin
            idx_r           <= '0;
            tdata_r         <= BASE_ADDR;
            tvalid_r        <= 1'b0;
            status_tready_r <= 1'b0;
            outstanding_r   <= 4'd0;
            chunks_done_r   <= 32'd0;
            last_bytes_r    <= 23'd0;
            error_r         <= 1'b0;
        end else begin
            idx_r           <= idx_next_s;
            // idx only moves on a handshake, so tdata stays put while a beat waits.
            tdata_r         <= chunk_addr_f(idx_next_s);
            tvalid_r        <= tvalid_next_s;
            status_tready_r <= 1'b1;
            outstanding_r   <= outstanding_next_s;
            error_r         <= error_r | fault_s;
            if (count_okay_s) begin
                chunks_done_r <= chunks_done_r + 32'd1;
                last_bytes_r  <= status_in_tdata[30:8];
            end else begin
                chunks_done_r <= chunks_done_r;
                last_bytes_r  <= last_bytes_r;
            end
        end
    end

    assign address_out_tdata  = tdata_r;
    assign address_out_tvalid = tvalid_r;
    assign status_in_tready   = status_tready_r;
    assign outstanding        = outstanding_r;
    assign chunks_done        = chunks_done_r;
    assign last_bytes         = last_bytes_r;
    assign error              = error_r;

endmodule

// File: tb/tb_s2mm_address_generator.sv
// ---------------------------------------------------------------------------
// Directed bench for s2mm_address_generator with default parameters.
// Expected chunk addresses are queued when a test sets up its traffic and are
// popped and compared whenever an address handshake is seen.
// ---------------------------------------------------------------------------
module tb_s2mm_address_generator;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        enable;
    logic [31:0] address_out_tdata;
    logic        address_out_tvalid;
    logic        address_out_tready;
    logic [31:0] status_in_tdata;
    logic        status_in_tvalid;
    logic        status_in_tready;
    logic [3:0]  outstanding;
    logic [31:0] chunks_done;
    logic [22:0] last_bytes;
    logic        error;

    localparam logic [31:0] ST_OKAY_1024 = {1'b1, 23'd1024, 1'b1, 3'b000, 4'h0};
    localparam logic [31:0] ST_SLVERR    = 32'h0000_0040;

    int          total = 0;
    int          bad   = 0;
    int          beats = 0;
    int          owed  = 0;
    logic        last_hs;
    logic [31:0] exp_a;
    logic [31:0] exp_q[$];

    s2mm_address_generator dut (
        .address_out_aclk    (clk),
        .address_out_aresetn (aresetn),
        .enable              (enable),
        .address_out_tdata   (address_out_tdata),
        .address_out_tvalid  (address_out_tvalid),
        .address_out_tready  (address_out_tready),
        .status_in_tdata     (status_in_tdata),
        .status_in_tvalid    (status_in_tvalid),
        .status_in_tready    (status_in_tready),
        .outstanding         (outstanding),
        .chunks_done         (chunks_done),
        .last_bytes          (last_bytes),
        .error               (error)
    );

    always #5 clk = ~clk;

    // Ring of 16 chunks of 1 KiB starting at 0.
    function automatic logic [31:0] exp_addr(input int i);
        return 32'((i % 16) * 1024);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge after inputs are driven: scores a handshake that the
    // coming posedge will complete, then advances to the next negedge.
    task automatic tick();
        last_hs = 1'b0;
        if (address_out_tvalid === 1'b1 && address_out_tready === 1'b1) begin
            last_hs = 1'b1;
            beats++;
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL beat_unexpected observed=%0h expected=none", address_out_tdata);
            end
            if (exp_q.size() != 0) begin
                exp_a = exp_q.pop_front();
                chk("beat_addr", address_out_tdata, exp_a);
            end
        end
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_tvalid"}, 32'(address_out_tvalid), 32'd0);
        chk({tag, "_tdata"}, address_out_tdata, 32'h0000_0000);
        chk({tag, "_outstanding"}, 32'(outstanding), 32'd0);
        chk({tag, "_chunks"}, chunks_done, 32'd0);
        chk({tag, "_last_bytes"}, 32'(last_bytes), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_st_tready"}, 32'(status_in_tready), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        aresetn            = 1'b0;
        enable             = 1'b0;
        address_out_tready = 1'b0;
        status_in_tvalid   = 1'b0;
        status_in_tdata    = 32'd0;
        tick();
        tick();
        check_reset_values(tag);
        aresetn = 1'b1;
        tick();
        chk({tag, "_st_tready_release"}, 32'(status_in_tready), 32'd1);
        exp_q.delete();
        beats = 0;
        owed  = 0;
    endtask

    initial begin
        aresetn            = 1'b0;
        enable             = 1'b0;
        address_out_tready = 1'b0;
        status_in_tvalid   = 1'b0;
        status_in_tdata    = 32'd0;
        @(negedge clk);

        // Reset state.
        do_reset("rst0");

        // Four beats then stall on the outstanding limit.
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_addr(i));
        enable             = 1'b1;
        address_out_tready = 1'b1;
        for (int c = 0; c < 12; c++) tick();
        chk("t1_beats", 32'(beats), 32'd4);
        chk("t1_tvalid", 32'(address_out_tvalid), 32'd0);
        chk("t1_outstanding", 32'(outstanding), 32'd4);
        enable = 1'b0;
        tick();
        tick();
        status_in_tdata  = ST_OKAY_1024;
        status_in_tvalid = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        status_in_tvalid = 1'b0;
        chk("t1_drain_outstanding", 32'(outstanding), 32'd0);
        chk("t1_chunks", chunks_done, 32'd4);
        chk("t1_last_bytes", 32'(last_bytes), 32'd1024);
        chk("t1_no_more_beats", 32'(beats), 32'd4);

        // Twenty beats with one OKAY status each; index wraps after 16.
        do_reset("rst1");
        for (int i = 0; i < 20; i++) exp_q.push_back(exp_addr(i));
        enable          = 1'b1;
        status_in_tdata = ST_OKAY_1024;
        for (int c = 0; c < 400 && beats < 20; c++) begin
            status_in_tvalid = (owed > 0);
            if (owed > 0) owed--;
            address_out_tready = (beats < 20);
            if (beats == 15) chk("t2_beat16_addr", address_out_tdata, 32'h0000_3C00);
            tick();
            if (last_hs) owed++;
        end
        address_out_tready = 1'b0;
        enable             = 1'b0;
        for (int c = 0; c < 40 && owed > 0; c++) begin
            status_in_tvalid = 1'b1;
            owed--;
            tick();
        end
        status_in_tvalid = 1'b0;
        tick();
        chk("t2_beats", 32'(beats), 32'd20);
        chk("t2_chunks", chunks_done, 32'd20);
        chk("t2_last_bytes", 32'(last_bytes), 32'd1024);
        chk("t2_outstanding", 32'(outstanding), 32'd0);
        chk("t2_error", 32'(error), 32'd0);

        // Back-pressure with enable dropped; reset also drops the beat left pending above.
        do_reset("rst2");
        enable = 1'b1;
        for (int c = 0; c < 20 && address_out_tvalid !== 1'b1; c++) tick();
        chk("t3_tvalid_up", 32'(address_out_tvalid), 32'd1);
        enable = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t3_hold_tvalid", 32'(address_out_tvalid), 32'd1);
            chk("t3_hold_tdata", address_out_tdata, 32'h0000_0000);
        end
        exp_q.push_back(exp_addr(0));
        address_out_tready = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) tick();
        chk("t3_beats", 32'(beats), 32'd1);
        chk("t3_tvalid_idle", 32'(address_out_tvalid), 32'd0);
        chk("t3_outstanding", 32'(outstanding), 32'd1);

        // SLVERR status halts the block.
        status_in_tdata  = ST_SLVERR;
        status_in_tvalid = 1'b1;
        tick();
        status_in_tvalid = 1'b0;
        chk("t4_error", 32'(error), 32'd1);
        chk("t4_chunks", chunks_done, 32'd0);
        chk("t4_outstanding", 32'(outstanding), 32'd0);
        enable = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        chk("t4_no_beats", 32'(beats), 32'd1);
        chk("t4_tvalid", 32'(address_out_tvalid), 32'd0);
        status_in_tdata  = ST_OKAY_1024;
        status_in_tvalid = 1'b1;
        tick();
        status_in_tvalid = 1'b0;
        chk("t4_halt_chunks", chunks_done, 32'd0);
        chk("t4_halt_last_bytes", 32'(last_bytes), 32'd0);
        chk("t4_halt_st_tready", 32'(status_in_tready), 32'd1);

        // Underflow fault, then a single-cycle reset.
        do_reset("rst3");
        status_in_tdata  = ST_OKAY_1024;
        status_in_tvalid = 1'b1;
        tick();
        status_in_tvalid = 1'b0;
        chk("t5_error", 32'(error), 32'd1);
        chk("t5_outstanding", 32'(outstanding), 32'd0);
        chk("t5_chunks", chunks_done, 32'd0);
        aresetn            = 1'b0;
        enable             = 1'b0;
        address_out_tready = 1'b0;
        tick();
        check_reset_values("t5_rst");
        aresetn = 1'b1;
        tick();
        chk("t5_st_tready_release", 32'(status_in_tready), 32'd1);
        chk("t5_error_cleared", 32'(error), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/s2mm_address_generator.md
S2MM_ADDRESS_GENERATOR -- requirements
Module: s2mm_address_generator

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, ring-buffer base byte address.
REQ-002 SHALL have parameter CHUNK_BYTES, default 1024, bytes per chunk; power of two, matches downstream command BTT.
REQ-003 SHALL have parameter NUM_CHUNKS, default 16, chunks in ring; power of two, 2..256.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, issued-but-uncompleted address limit, 1..15.
REQ-005 SHALL have port address_out_aclk  in  1  single clock; all logic rising-edge.
REQ-006 SHALL have port address_out_aresetn  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port enable  in  1  level; 1 = generate addresses.
REQ-008 SHALL have port address_out_tdata  out  32  chunk start address, feeds the S2MM command converter.
REQ-009 SHALL have port address_out_tvalid  out  1  AXI-Stream valid.
REQ-010 SHALL have port address_out_tready  in  1  AXI-Stream ready.
REQ-011 SHALL have port status_in_tdata  in  32  datamover S2MM status, indeterminate-BTT format: [31] EOP, [30:8] bytes received, [7] OKAY, [6] SLVERR, [5] DECERR, [4] INTERR, [3:0] TAG.
REQ-012 SHALL have port status_in_tvalid  in  1  status valid.
REQ-013 SHALL have port status_in_tready  out  1  status ready.
REQ-014 SHALL have port outstanding  out  4  issued minus completed count.
REQ-015 SHALL have port chunks_done  out  32  OKAY statuses received, wraps at 2^32.
REQ-016 SHALL have port last_bytes  out  23  bytes field of most recent OKAY status.
REQ-017 SHALL have port error  out  1  sticky fault flag.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, HALT.
REQ-019 SHALL go IDLE->ISSUE when enable=1; ISSUE->IDLE when enable=0 and no beat pending; any state->HALT on fault; HALT exits only via reset.
REQ-020 SHALL assert address_out_tvalid in ISSUE when outstanding < MAX_OUTSTANDING; tvalid registered, asserted from the cycle after the condition becomes true.
REQ-021 SHALL hold tvalid and tdata stable once asserted until address_out_tready=1; enable drop or fault SHALL NOT withdraw a pending beat.
REQ-022 SHALL drive address_out_tdata = BASE_ADDR + idx*CHUNK_BYTES, idx 0..NUM_CHUNKS-1, 32-bit truncated sum.
REQ-023 SHALL increment idx on each address handshake, wrapping NUM_CHUNKS-1 -> 0; idx preserved across IDLE.
REQ-024 SHALL increment outstanding on address handshake, decrement on status handshake; both in one cycle -> unchanged.
REQ-025 SHALL allow back-to-back address beats (one per cycle) while outstanding stays below MAX_OUTSTANDING.
REQ-026 SHALL drive status_in_tready = 1 in every non-reset cycle, all states including HALT.
REQ-027 SHALL on status handshake with [7]=1 and [6:4]=0: chunks_done += 1, last_bytes <= [30:8], next cycle.
REQ-028 SHALL treat as fault: status with [7]=0 or any of [6:4]=1; status handshake while outstanding=0 (underflow, counter held at 0).
REQ-029 SHALL on fault set error=1 the next cycle and enter HALT; no new tvalid assertion after the pending beat completes.
REQ-030 SHALL in HALT keep consuming statuses and decrementing outstanding; chunks_done/last_bytes frozen.

Reset
REQ-031 SHALL on address_out_aresetn=0 at a clock edge set: state IDLE, idx 0, address_out_tvalid 0, address_out_tdata BASE_ADDR, outstanding 0, chunks_done 0, last_bytes 0, error 0, status_in_tready 0.
REQ-032 SHALL abandon any pending beat when reset is asserted mid-operation; status_in_tready SHALL return to 1 the first cycle after reset release.

Verification
REQ-033 SHALL verify: enable=1, tready=1, statuses never sent -> exactly 4 beats 0x0,0x400,0x800,0xC00, then tvalid=0, outstanding=4.
REQ-034 SHALL verify: steady issue with one OKAY status (bytes=1024) per beat for 20 beats -> 16th beat 0x3C00, 17th beat 0x0, chunks_done=20, last_bytes=1024.
REQ-035 SHALL verify: tready=0 for 5 cycles while tvalid=1, enable dropped meanwhile -> tdata stable, beat completes when tready=1, then IDLE.
REQ-036 SHALL verify: status 0x0000_0040 (SLVERR) -> error=1 next cycle, no further beats, chunks_done unchanged.
REQ-037 SHALL verify: status handshake with outstanding=0 -> error=1, outstanding stays 0; then aresetn low one cycle -> all outputs at REQ-031 values.
